id_stage_decoder: RTL and testbench

Registered instruction-decode stage for the two-accumulator (A/B) pipelined core, sitting between the instruction-ROM fetch stage and the execute stage. It decodes the 6-bit opcode into the existing control bundle (accumulator write enables, ALU operand muxes, memory read/write, write-back select, store select, jump, branch condition). On top of that bundle it adds:
- a valid/ready handshake;
- a one-bubble load-use interlock;
- a synchronous flush from branch resolution;
- illegal-opcode flagging;
- a saturating stall counter.

---
 rtl/id_stage_decoder_pkg.sv | 78 +++++++
 rtl/id_stage_decoder_inst_decode_comb.sv | 48 ++++
 rtl/id_stage_decoder.sv | 109 ++++++++++
 tb/tb_id_stage_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_decoder_pkg.sv
// Shared definitions for the decode stage: opcode map, branch-condition codes,
// store-select codes and the registered control bundle.
package id_stage_decoder_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_LDA   = 6'h00;
  localparam logic [OPC_W-1:0] OP_LDB   = 6'h01;
  localparam logic [OPC_W-1:0] OP_STA   = 6'h02;
  localparam logic [OPC_W-1:0] OP_STB   = 6'h03;
  localparam logic [OPC_W-1:0] OP_ADDA  = 6'h04;
  localparam logic [OPC_W-1:0] OP_ADDB  = 6'h05;
  localparam logic [OPC_W-1:0] OP_SUBA  = 6'h06;
  localparam logic [OPC_W-1:0] OP_SUBB  = 6'h07;
  localparam logic [OPC_W-1:0] OP_ANDA  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ANDB  = 6'h09;
  localparam logic [OPC_W-1:0] OP_ORA   = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ORB   = 6'h0B;
  localparam logic [OPC_W-1:0] OP_LDCA  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_LDCB  = 6'h0D;
  localparam logic [OPC_W-1:0] OP_ADDCA = 6'h0E;
  localparam logic [OPC_W-1:0] OP_ADDCB = 6'h0F;
  localparam logic [OPC_W-1:0] OP_SUBCA = 6'h10;
  localparam logic [OPC_W-1:0] OP_SUBCB = 6'h11;
  localparam logic [OPC_W-1:0] OP_ANDCA = 6'h12;
  localparam logic [OPC_W-1:0] OP_ANDCB = 6'h13;
  localparam logic [OPC_W-1:0] OP_ORCA  = 6'h14;
  localparam logic [OPC_W-1:0] OP_ORCB  = 6'h15;
  localparam logic [OPC_W-1:0] OP_ASLA  = 6'h16;
  localparam logic [OPC_W-1:0] OP_ASRA  = 6'h17;
  localparam logic [OPC_W-1:0] OP_JMP   = 6'h18;
  localparam logic [OPC_W-1:0] OP_BAEQ  = 6'h20;
  localparam logic [OPC_W-1:0] OP_BANE  = 6'h21;
  localparam logic [OPC_W-1:0] OP_BACS  = 6'h22;
  localparam logic [OPC_W-1:0] OP_BACC  = 6'h23;
  localparam logic [OPC_W-1:0] OP_BAMI  = 6'h24;
  localparam logic [OPC_W-1:0] OP_BAPL  = 6'h25;
  localparam logic [OPC_W-1:0] OP_BBEQ  = 6'h26;
  localparam logic [OPC_W-1:0] OP_BBNE  = 6'h27;
  localparam logic [OPC_W-1:0] OP_BBCS  = 6'h28;
  localparam logic [OPC_W-1:0] OP_BBCC  = 6'h29;
  localparam logic [OPC_W-1:0] OP_BBMI  = 6'h2A;
  localparam logic [OPC_W-1:0] OP_BBPL  = 6'h2B;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BAEQ = 4'd1;
  localparam logic [3:0] BR_BANE = 4'd2;
  localparam logic [3:0] BR_BACS = 4'd3;
  localparam logic [3:0] BR_BACC = 4'd4;
  localparam logic [3:0] BR_BAMI = 4'd5;
  localparam logic [3:0] BR_BAPL = 4'd6;
  localparam logic [3:0] BR_BBEQ = 4'd7;
  localparam logic [3:0] BR_BBNE = 4'd8;
  localparam logic [3:0] BR_BBCS = 4'd9;
  localparam logic [3:0] BR_BBCC = 4'd10;
  localparam logic [3:0] BR_BBMI = 4'd11;
  localparam logic [3:0] BR_BBPL = 4'd12;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2
  } store_sel_e;

  typedef struct packed {
    logic       write_a;
    logic       write_b;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_we;
    logic       wb_mem;
    store_sel_e store_sel;
    logic       jump;
    logic [3:0] branch;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/id_stage_decoder_inst_decode_comb.sv
// Purely combinational opcode decode into the control bundle, plus which
// accumulators the instruction reads (used by the load-use interlock).
module inst_decode_comb
  import id_stage_decoder_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl,
  output logic             reads_a,
  output logic             reads_b
);

  always_comb begin
    ctrl    = '0;
    reads_a = 1'b0;
    reads_b = 1'b0;
    case (opcode)
      OP_LDA: begin ctrl.write_a = 1'b1; ctrl.wb_mem = 1'b1; end
      OP_LDB: begin ctrl.write_b = 1'b1; ctrl.wb_mem = 1'b1; end
      OP_STA: begin ctrl.mem_we = 1'b1; ctrl.store_sel = ST_A; reads_a = 1'b1; end
      OP_STB: begin ctrl.mem_we = 1'b1; ctrl.store_sel = ST_B; reads_b = 1'b1; end
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA: begin
        ctrl.write_a = 1'b1; reads_a = 1'b1; reads_b = 1'b1;
      end
      OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin
        ctrl.write_b = 1'b1; reads_a = 1'b1; reads_b = 1'b1;
      end
      // Load-constant passes the constant through the ALU against a zero operand
      OP_LDCA: begin ctrl.write_a = 1'b1; ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = 1'b1; end
      OP_LDCB: begin ctrl.write_b = 1'b1; ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = 1'b1; end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA, OP_ASLA, OP_ASRA: begin
        ctrl.write_a = 1'b1; ctrl.alu_src_b = 1'b1; reads_a = 1'b1;
      end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin
        ctrl.write_b = 1'b1; ctrl.alu_src_b = 1'b1; reads_b = 1'b1;
      end
      OP_JMP: ctrl.jump = 1'b1;
      // Branch opcodes are contiguous and in the same order as the BR_ codes
      OP_BAEQ, OP_BANE, OP_BACS, OP_BACC, OP_BAMI, OP_BAPL: begin
        ctrl.branch = BR_BAEQ + 4'(opcode - OP_BAEQ); reads_a = 1'b1;
      end
      OP_BBEQ, OP_BBNE, OP_BBCS, OP_BBCC, OP_BBMI, OP_BBPL: begin
        ctrl.branch = BR_BAEQ + 4'(opcode - OP_BAEQ); reads_b = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_decoder.sv
// Registered instruction-decode stage: valid/ready handshake, one-bubble
// load-use interlock, flush, illegal flagging and a saturating stall counter.
module id_stage_decoder
  import id_stage_decoder_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16,
  parameter int LU_STALL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_ready,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_const,
  output logic              id_write_a,
  output logic              id_write_b,
  output logic              id_alu_src_a,
  output logic              id_alu_src_b,
  output logic              id_mem_we,
  output logic              id_wb_mem,
  output logic [1:0]        id_store_sel,
  output logic              id_jump,
  output logic [3:0]        id_branch,
  output logic              id_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [OPC_W-1:0]  opcode;
  ctrl_t             dec_ctrl;
  ctrl_t             ctrl_q;
  logic              dec_reads_a;
  logic              dec_reads_b;
  logic [DATA_W-1:0] dec_const;
  logic [DATA_W-1:0] const_q;
  logic              valid_q;
  logic              hazard;

  assign opcode = if_inst[INST_W-1 -: OPC_W];

  inst_decode_comb u_decode (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .reads_a (dec_reads_a),
    .reads_b (dec_reads_b)
  );

  always_comb begin
    dec_const = '0;
    for (int i = 0; i < DATA_W && i < INST_W - OPC_W; i++) dec_const[i] = if_inst[i];
  end

  // A load in the register feeding an accumulator the incoming instruction reads
  assign hazard = (LU_STALL != 0) && valid_q && ctrl_q.wb_mem && if_valid &&
                  ((ctrl_q.write_a && dec_reads_a) || (ctrl_q.write_b && dec_reads_b));

  assign id_ready = flush || ((!valid_q || ex_ready) && !hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      const_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      const_q <= '0;
    end else if (valid_q && !ex_ready) begin
      valid_q <= valid_q;
    end else if (hazard || !if_valid) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      const_q <= '0;
    end else begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      const_q <= dec_const;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (!flush && hazard && ex_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign id_valid     = valid_q;
  assign id_const     = const_q;
  assign id_write_a   = ctrl_q.write_a;
  assign id_write_b   = ctrl_q.write_b;
  assign id_alu_src_a = ctrl_q.alu_src_a;
  assign id_alu_src_b = ctrl_q.alu_src_b;
  assign id_mem_we    = ctrl_q.mem_we;
  assign id_wb_mem    = ctrl_q.wb_mem;
  assign id_store_sel = ctrl_q.store_sel;
  assign id_jump      = ctrl_q.jump;
  assign id_branch    = ctrl_q.branch;
  assign id_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Directed plus randomized bench for id_stage_decoder; three instances share the
// stimulus: interlocked, interlock disabled, and a 2-bit stall counter.
module tb_id_stage_decoder;
  import id_stage_decoder_pkg::*;

  typedef struct {
    bit v, wa, wb, sa, sb, we, wbm, j, ill;
    bit [1:0]  ss;
    bit [3:0]  br;
    bit [15:0] c;
  } exp_t;

  localparam logic [5:0] BR_OPS [12] = '{OP_BAEQ, OP_BANE, OP_BACS, OP_BACC, OP_BAMI, OP_BAPL,
                                         OP_BBEQ, OP_BBNE, OP_BBCS, OP_BBCC, OP_BBMI, OP_BBPL};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] if_inst = '0;

  logic        rdy [3], vld [3], wa [3], wb [3], sa [3], sb [3], we [3], wbm [3], jmp [3], ill [3];
  logic [1:0]  ss [3];
  logic [3:0]  br [3];
  logic [15:0] cst [3];
  logic [15:0] cnt_main, cnt_nolu;
  logic [1:0]  cnt_sat;

  exp_t        m [2];
  int unsigned e_main, e_nolu, e_sat;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  id_stage_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .id_ready(rdy[0]),
    .ex_ready(ex_ready), .flush(flush), .cnt_clr(cnt_clr), .id_valid(vld[0]), .id_const(cst[0]),
    .id_write_a(wa[0]), .id_write_b(wb[0]), .id_alu_src_a(sa[0]), .id_alu_src_b(sb[0]),
    .id_mem_we(we[0]), .id_wb_mem(wbm[0]), .id_store_sel(ss[0]), .id_jump(jmp[0]),
    .id_branch(br[0]), .id_illegal(ill[0]), .stall_cnt(cnt_main));

  id_stage_decoder #(.LU_STALL(0)) u_nolu (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .id_ready(rdy[1]),
    .ex_ready(ex_ready), .flush(flush), .cnt_clr(cnt_clr), .id_valid(vld[1]), .id_const(cst[1]),
    .id_write_a(wa[1]), .id_write_b(wb[1]), .id_alu_src_a(sa[1]), .id_alu_src_b(sb[1]),
    .id_mem_we(we[1]), .id_wb_mem(wbm[1]), .id_store_sel(ss[1]), .id_jump(jmp[1]),
    .id_branch(br[1]), .id_illegal(ill[1]), .stall_cnt(cnt_nolu));

  id_stage_decoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .id_ready(rdy[2]),
    .ex_ready(ex_ready), .flush(flush), .cnt_clr(cnt_clr), .id_valid(vld[2]), .id_const(cst[2]),
    .id_write_a(wa[2]), .id_write_b(wb[2]), .id_alu_src_a(sa[2]), .id_alu_src_b(sb[2]),
    .id_mem_we(we[2]), .id_wb_mem(wbm[2]), .id_store_sel(ss[2]), .id_jump(jmp[2]),
    .id_branch(br[2]), .id_illegal(ill[2]), .stall_cnt(cnt_sat));

  function automatic exp_t empty_b();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic bit reads_a(logic [5:0] op);
    return op inside {OP_STA, OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB, OP_ANDA, OP_ANDB, OP_ORA, OP_ORB,
                      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA, OP_ASLA, OP_ASRA,
                      OP_BAEQ, OP_BANE, OP_BACS, OP_BACC, OP_BAMI, OP_BAPL};
  endfunction

  function automatic bit reads_b(logic [5:0] op);
    return op inside {OP_STB, OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB, OP_ANDA, OP_ANDB, OP_ORA, OP_ORB,
                      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB,
                      OP_BBEQ, OP_BBNE, OP_BBCS, OP_BBCC, OP_BBMI, OP_BBPL};
  endfunction

  function automatic exp_t ref_decode(logic [15:0] inst);
    logic [5:0] op;
    exp_t e;
    op  = inst[15:10];
    e   = empty_b();
    e.v = 1;
    e.c = {6'b0, inst[9:0]};
    if (!(op <= OP_JMP || (op >= OP_BAEQ && op <= OP_BBPL))) begin
      e.ill = 1;
      return e;
    end
    e.wa  = op inside {OP_LDA, OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA, OP_LDCA, OP_ADDCA, OP_SUBCA,
                       OP_ANDCA, OP_ORCA, OP_ASLA, OP_ASRA};
    e.wb  = op inside {OP_LDB, OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB, OP_LDCB, OP_ADDCB, OP_SUBCB,
                       OP_ANDCB, OP_ORCB};
    e.sa  = op inside {OP_LDCA, OP_LDCB};
    e.sb  = op inside {OP_LDCA, OP_LDCB, OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA, OP_ASLA, OP_ASRA,
                       OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB};
    e.we  = op inside {OP_STA, OP_STB};
    e.wbm = op inside {OP_LDA, OP_LDB};
    e.ss  = (op == OP_STA) ? 2'd1 : (op == OP_STB) ? 2'd2 : 2'd0;
    e.j   = (op == OP_JMP);
    for (int i = 0; i < 12; i++) if (op == BR_OPS[i]) e.br = 4'(i + 1);
    return e;
  endfunction

  function automatic bit dep(exp_t s, bit lu);
    logic [5:0] op;
    op = if_inst[15:10];
    return lu && s.v && s.wbm && if_valid && ((s.wa && reads_a(op)) || (s.wb && reads_b(op)));
  endfunction

  function automatic logic [31:0] pack_e(exp_t e);
    return {1'b0, e.v, e.wa, e.wb, e.sa, e.sb, e.we, e.wbm, e.ss, e.j, e.br, e.ill, e.c};
  endfunction

  function automatic logic [31:0] pack_o(int k);
    return {1'b0, vld[k], wa[k], wb[k], sa[k], sb[k], we[k], wbm[k], ss[k], jmp[k], br[k], ill[k], cst[k]};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_miss++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m[0] = empty_b();
    m[1] = empty_b();
    e_main = 0;
    e_nolu = 0;
    e_sat  = 0;
  endtask

  task automatic model_edge();
    bit d, inc;
    for (int k = 0; k < 2; k++) begin
      d   = dep(m[k], k == 0);
      inc = 0;
      if (flush) m[k] = empty_b();
      else if (m[k].v && !ex_ready) m[k] = m[k];
      else if (d) begin m[k] = empty_b(); inc = 1; end
      else if (if_valid) m[k] = ref_decode(if_inst);
      else m[k] = empty_b();
      if (k == 0) begin
        if (cnt_clr) begin e_main = 0; e_sat = 0; end
        else if (inc) begin
          if (e_main < 65535) e_main++;
          if (e_sat < 3) e_sat++;
        end
      end else begin
        if (cnt_clr) e_nolu = 0;
        else if (inc && e_nolu < 65535) e_nolu++;
      end
    end
  endtask

  // One clock: check ready before the edge, advance the model, check the bundle after it
  task automatic step(input string tag);
    int mi;
    #1;
    for (int k = 0; k < 3; k++) begin
      mi = (k == 1) ? 1 : 0;
      check($sformatf("%s/ready%0d", tag, k), 32'(rdy[k]),
            32'(flush || ((!m[mi].v || ex_ready) && !dep(m[mi], k != 1))));
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      mi = (k == 1) ? 1 : 0;
      check($sformatf("%s/bundle%0d", tag, k), pack_o(k), pack_e(m[mi]));
    end
    check({tag, "/cnt_main"}, 32'(cnt_main), e_main);
    check({tag, "/cnt_nolu"}, 32'(cnt_nolu), e_nolu);
    check({tag, "/cnt_sat"}, 32'(cnt_sat), e_sat);
  endtask

  task automatic present(input bit v, input logic [5:0] op, input logic [9:0] c);
    if_valid = v;
    if_inst  = {op, c};
  endtask

  function automatic logic [15:0] rand_inst();
    int r, x;
    logic [5:0] op;
    r = $urandom_range(0, 9);
    if (r < 3) op = 6'($urandom_range(0, 1));
    else if (r == 9) op = 6'($urandom_range(0, 63));
    else begin
      x  = $urandom_range(0, 36);
      op = (x < 25) ? 6'(x) : 6'(32 + x - 25);
    end
    return {op, 10'($urandom_range(0, 1023))};
  endfunction

  initial begin
    model_reset();
    #2;
    check("reset/bundle", pack_o(0), 32'd0);
    check("reset/cnt", 32'(cnt_main), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    check("reset/ready", 32'(rdy[0]), 32'd1);

    ex_ready = 1'b1;
    present(1, OP_LDCA, 10'h005); step("ldca");
    check("ldca/ctl", {29'd0, wa[0], sa[0], sb[0]}, 32'd7);
    check("ldca/const", 32'(cst[0]), 32'h005);
    present(1, OP_ADDCA, 10'h003); step("addca");
    check("addca/ctl", {29'd0, wa[0], sa[0], sb[0]}, 32'd5);
    check("addca/const", 32'(cst[0]), 32'h003);
    check("addca/cnt", 32'(cnt_main), 32'd0);

    present(1, OP_LDA, 10'h010); step("lu_lda");
    present(1, OP_ADDA, 10'h000); step("lu_bubble");
    check("lu_bubble/valid", 32'(vld[0]), 32'd0);
    check("lu_bubble/nolu_valid", 32'(vld[1]), 32'd1);
    check("lu_bubble/cnt", 32'(cnt_main), 32'd1);
    step("lu_adda");
    check("lu_adda/valid", {30'd0, vld[0], wa[0]}, 32'd3);

    present(1, OP_LDB, 10'h001); step("nd_ldb");
    present(1, OP_ADDCA, 10'h002); step("nd_addca");
    check("nd_addca/valid", {30'd0, vld[0], wa[0]}, 32'd3);
    check("nd_addca/cnt", 32'(cnt_main), 32'd1);

    present(1, OP_STB, 10'h020); step("bp_stb");
    ex_ready = 1'b0;
    present(1, OP_ADDA, 10'h000);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp_hold/held", {28'd0, vld[0], we[0], ss[0]}, 32'hE);
    end
    ex_ready = 1'b1; step("bp_release");
    check("bp_release/adda", {29'd0, wa[0], ss[0]}, 32'd4);

    present(1, OP_BANE, 10'h040); step("fl_bane");
    check("fl_bane/branch", 32'(br[0]), 32'(BR_BANE));
    present(1, OP_LDA, 10'h011); flush = 1'b1; step("fl_drop");
    check("fl_drop/valid", {30'd0, vld[0], wbm[0]}, 32'd0);
    flush = 1'b0;
    present(1, OP_LDA, 10'h012); step("flh_lda");
    present(1, OP_ADDA, 10'h000); flush = 1'b1; step("flh_flush");
    check("flh_flush/cnt", 32'(cnt_main), 32'd1);
    flush = 1'b0;

    present(1, 6'h3F, 10'h155); step("illegal");
    check("illegal/flag", {30'd0, vld[0], ill[0]}, 32'd3);
    check("illegal/ctl", {18'd0, wa[0], wb[0], sa[0], sb[0], we[0], wbm[0], ss[0], jmp[0], br[0]}, 32'd0);
    check("illegal/const", 32'(cst[0]), 32'h155);

    for (int i = 0; i < 4; i++) begin
      present(1, OP_LDA, 10'h013); step("sat_lda");
      present(1, OP_ADDA, 10'h000); step("sat_adda");
    end
    check("sat/cnt_sat", 32'(cnt_sat), 32'd3);
    check("sat/cnt_main", 32'(cnt_main), 32'd5);

    present(1, OP_LDA, 10'h014); step("clr_lda");
    present(1, OP_ADDA, 10'h000); cnt_clr = 1'b1; step("clr_hazard");
    check("clr_hazard/cnt", 32'(cnt_main), 32'd0);
    cnt_clr = 1'b0;

    present(1, OP_LDA, 10'h015); step("rs_lda");
    ex_ready = 1'b0;
    present(1, OP_ADDA, 10'h000); step("rs_hold");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rs_async/valid", 32'(vld[0]), 32'd0);
    #5 rst_n = 1'b1;
    ex_ready = 1'b1;
    step("rs_first");
    check("rs_first/adda", {30'd0, vld[0], wa[0]}, 32'd3);

    for (int i = 0; i < 400; i++) begin
      if_inst  = rand_inst();
      if_valid = ($urandom_range(0, 9) < 8);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
